// File: rtl/parallel_transfer_ctrl_if.sv
// Command/transfer-register bus for parallel_transfer_ctrl.
// master: the requester (front panel / test stimulus); slave: the controller.
interface parallel_transfer_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic [1:0]       cmd;
  logic [WIDTH-1:0] data_in;
  logic             cmd_ready;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  modport master (
    output cmd_valid, cmd, data_in,
    input  cmd_ready, busy, done, err, a, b
  );

  modport slave (
    input  cmd_valid, cmd, data_in,
    output cmd_ready, busy, done, err, a, b
  );
endinterface

// File: rtl/parallel_transfer_ctrl.sv
// parallel_transfer_ctrl: command-driven sequencer owning transfer registers a and b.
// One command at a time is accepted over cmd_valid/cmd_ready and applied as a
// fixed-latency move: LOAD_A, A_TO_B, SWAP or CLEAR, acknowledged by done/err.
// Build option: define PDT_SWAP_EN to implement SWAP (SWP1/SWP2 states and tmp).
// Without it, SWAP is still accepted but answered with an err pulse.
module parallel_transfer_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  parallel_transfer_ctrl_if.slave  bus
);

  localparam logic [1:0] OP_LOAD_A = 2'b00;
  localparam logic [1:0] OP_A_TO_B = 2'b01;
  localparam logic [1:0] OP_SWAP   = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
`ifdef PDT_SWAP_EN
    ST_SWP1 = 3'd2,
    ST_SWP2 = 3'd3,
`endif
    ST_FIN  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_cmd_q;
  logic [WIDTH-1:0] r_data_q;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
`ifdef PDT_SWAP_EN
  logic [WIDTH-1:0] r_tmp;
`endif

  logic w_ready;
  logic w_accept;

  // Ready only in IDLE, and never while reset is asserted.
  assign w_ready  = (r_state == ST_IDLE) && !i_rst;
  assign w_accept = bus.cmd_valid && w_ready;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode. Unsupported opcodes pass through EXEC so that err
  // lands on the same cycle a done would for a single-cycle command.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
`ifdef PDT_SWAP_EN
          if (bus.cmd == OP_SWAP) begin
            w_state_nxt = ST_SWP1;
          end else begin
            w_state_nxt = ST_EXEC;
          end
`else
          w_state_nxt = ST_EXEC;
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (r_cmd_q == OP_SWAP) begin
          w_state_nxt = ST_ERR;
        end else begin
          w_state_nxt = ST_FIN;
        end
      end
`ifdef PDT_SWAP_EN
      ST_SWP1: w_state_nxt = ST_SWP2;
      ST_SWP2: w_state_nxt = ST_FIN;
`endif
      ST_FIN:  w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command capture and transfer-register moves; reset discards any partial swap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmd_q  <= 2'b00;
      r_data_q <= {WIDTH{1'b0}};
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
`ifdef PDT_SWAP_EN
      r_tmp    <= {WIDTH{1'b0}};
`endif
    end else begin
      if (w_accept) begin
        r_cmd_q  <= bus.cmd;
        r_data_q <= bus.data_in;
      end
      case (r_state)
        ST_EXEC: begin
          case (r_cmd_q)
            OP_LOAD_A: r_a <= r_data_q;
            OP_A_TO_B: r_b <= r_a;
            OP_CLEAR: begin
              r_a <= {WIDTH{1'b0}};
              r_b <= {WIDTH{1'b0}};
            end
            default: begin
              r_a <= r_a;
              r_b <= r_b;
            end
          endcase
        end
`ifdef PDT_SWAP_EN
        ST_SWP1: begin
          r_tmp <= r_a;
          r_a   <= r_b;
        end
        ST_SWP2: begin
          r_b <= r_tmp;
        end
`endif
        default: begin
          r_a <= r_a;
          r_b <= r_b;
        end
      endcase
    end
  end

  // Status outputs decode directly from the state register.
  assign bus.cmd_ready = w_ready;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = (r_state == ST_FIN);
  assign bus.err       = (r_state == ST_ERR);
  assign bus.a         = r_a;
  assign bus.b         = r_b;

endmodule

// File: tb/tb_parallel_transfer_ctrl.sv
// Directed self-checking bench for parallel_transfer_ctrl (works with or without PDT_SWAP_EN).
module tb_parallel_transfer_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  parallel_transfer_ctrl_if #(.WIDTH(4)) bif ();

  parallel_transfer_ctrl #(.WIDTH(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and wait (bounded) for its done/err pulse.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] d);
    int k;
    bif.cmd_valid = 1'b1;
    bif.cmd       = op;
    bif.data_in   = d;
    tick();
    bif.cmd_valid = 1'b0;
    k = 0;
    while (!(bif.done || bif.err) && k < 8) begin
      tick();
      k++;
    end
    n_vec++;
    if (k >= 8) begin
      n_err++;
      $display("FAIL run_cmd_timeout: op=%0d got no done/err within 8 cycles", op);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.cmd_valid = 1'b0;
    bif.cmd = 2'b00;
    bif.data_in = 4'd0;
    tick();
    tick();
    n_vec++; if (bif.cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_gated: got %b expected 0", bif.cmd_ready); end
    n_vec++; if (bif.a !== 4'd0 || bif.b !== 4'd0) begin n_err++; $display("FAIL reset_regs: a=%0d b=%0d expected 0 0", bif.a, bif.b); end
    n_vec++; if (bif.done !== 1'b0 || bif.err !== 1'b0 || bif.busy !== 1'b0) begin n_err++; $display("FAIL reset_flags: done=%b err=%b busy=%b expected 0 0 0", bif.done, bif.err, bif.busy); end
    rst = 1'b0;
    #1;
    n_vec++; if (bif.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_release: got %b expected 1", bif.cmd_ready); end
  endtask

  task automatic test_load();
    bif.cmd_valid = 1'b1;
    bif.cmd = 2'b00;
    bif.data_in = 4'd5;
    tick();
    bif.cmd_valid = 1'b0;
    n_vec++; if (bif.cmd_ready !== 1'b0 || bif.busy !== 1'b1) begin n_err++; $display("FAIL load_n: ready=%b busy=%b expected 0 1", bif.cmd_ready, bif.busy); end
    n_vec++; if (bif.done !== 1'b0 || bif.a !== 4'd0) begin n_err++; $display("FAIL load_n_regs: done=%b a=%0d expected 0 0", bif.done, bif.a); end
    tick();
    n_vec++; if (bif.a !== 4'd5 || bif.b !== 4'd0) begin n_err++; $display("FAIL load_n1_regs: a=%0d b=%0d expected 5 0", bif.a, bif.b); end
    n_vec++; if (bif.done !== 1'b1 || bif.cmd_ready !== 1'b0) begin n_err++; $display("FAIL load_n1_done: done=%b ready=%b expected 1 0", bif.done, bif.cmd_ready); end
    tick();
    n_vec++; if (bif.done !== 1'b0 || bif.cmd_ready !== 1'b1 || bif.busy !== 1'b0) begin n_err++; $display("FAIL load_n2: done=%b ready=%b busy=%b expected 0 1 0", bif.done, bif.cmd_ready, bif.busy); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [3];
    logic [3:0] dat [3];
    int acc [3];
    int nacc;
    int ndone;
    logic took;
    ops = '{2'b00, 2'b01, 2'b00};
    dat = '{4'd3, 4'd15, 4'd9};
    nacc = 0;
    ndone = 0;
    bif.cmd_valid = 1'b1;
    bif.cmd = ops[0];
    bif.data_in = dat[0];
    for (int c = 0; c < 12; c++) begin
      took = bif.cmd_valid && bif.cmd_ready;
      tick();
      if (took) begin
        acc[nacc] = c;
        nacc++;
        if (nacc < 3) begin
          bif.cmd = ops[nacc];
          bif.data_in = dat[nacc];
        end else begin
          bif.cmd_valid = 1'b0;
        end
      end
      if (bif.done === 1'b1) ndone++;
    end
    n_vec++; if (nacc !== 3) begin n_err++; $display("FAIL b2b_accepts: got %0d expected 3", nacc); end
    n_vec++; if (nacc == 3 && (acc[0] !== 0 || acc[1] !== 3 || acc[2] !== 6)) begin n_err++; $display("FAIL b2b_spacing: accepted at %0d %0d %0d expected 0 3 6", acc[0], acc[1], acc[2]); end
    n_vec++; if (ndone !== 3) begin n_err++; $display("FAIL b2b_done_count: got %0d expected 3", ndone); end
    n_vec++; if (bif.a !== 4'd9 || bif.b !== 4'd3) begin n_err++; $display("FAIL b2b_regs: a=%0d b=%0d expected 9 3", bif.a, bif.b); end
  endtask

  task automatic test_swap();
    bif.cmd_valid = 1'b1;
    bif.cmd = 2'b10;
    bif.data_in = 4'd0;
    tick();
    bif.cmd_valid = 1'b0;
    n_vec++; if (bif.cmd_ready !== 1'b0 || bif.a !== 4'd9) begin n_err++; $display("FAIL swap_n: ready=%b a=%0d expected 0 9", bif.cmd_ready, bif.a); end
    tick();
`ifdef PDT_SWAP_EN
    n_vec++; if (bif.a !== 4'd3 || bif.b !== 4'd3 || bif.done !== 1'b0) begin n_err++; $display("FAIL swap_n1: a=%0d b=%0d done=%b expected 3 3 0", bif.a, bif.b, bif.done); end
    tick();
    n_vec++; if (bif.a !== 4'd3 || bif.b !== 4'd9 || bif.done !== 1'b1 || bif.err !== 1'b0) begin n_err++; $display("FAIL swap_n2: a=%0d b=%0d done=%b err=%b expected 3 9 1 0", bif.a, bif.b, bif.done, bif.err); end
    tick();
    n_vec++; if (bif.done !== 1'b0 || bif.cmd_ready !== 1'b1) begin n_err++; $display("FAIL swap_n3: done=%b ready=%b expected 0 1", bif.done, bif.cmd_ready); end
    // restore a=9, b=3 by swapping back
    run_cmd(2'b10, 4'd0);
`else
    n_vec++; if (bif.err !== 1'b1 || bif.done !== 1'b0) begin n_err++; $display("FAIL swap_off_n1: err=%b done=%b expected 1 0", bif.err, bif.done); end
    n_vec++; if (bif.a !== 4'd9 || bif.b !== 4'd3 || bif.cmd_ready !== 1'b0) begin n_err++; $display("FAIL swap_off_regs: a=%0d b=%0d ready=%b expected 9 3 0", bif.a, bif.b, bif.cmd_ready); end
    tick();
    n_vec++; if (bif.err !== 1'b0 || bif.cmd_ready !== 1'b1) begin n_err++; $display("FAIL swap_off_n2: err=%b ready=%b expected 0 1", bif.err, bif.cmd_ready); end
`endif
    n_vec++; if (bif.a !== 4'd9 || bif.b !== 4'd3) begin n_err++; $display("FAIL swap_end: a=%0d b=%0d expected 9 3", bif.a, bif.b); end
  endtask

  task automatic test_data_hold();
    bif.cmd_valid = 1'b1;
    bif.cmd = 2'b00;
    bif.data_in = 4'd7;
    tick();
    bif.cmd_valid = 1'b0;
    bif.data_in = 4'd2;
    tick();
    n_vec++; if (bif.a !== 4'd7 || bif.done !== 1'b1) begin n_err++; $display("FAIL data_hold: a=%0d done=%b expected 7 1", bif.a, bif.done); end
    tick();
  endtask

  task automatic test_clear();
    run_cmd(2'b00, 4'd4);
    run_cmd(2'b01, 4'd0);
    run_cmd(2'b00, 4'd6);
    n_vec++; if (bif.a !== 4'd6 || bif.b !== 4'd4) begin n_err++; $display("FAIL clear_setup: a=%0d b=%0d expected 6 4", bif.a, bif.b); end
    bif.cmd_valid = 1'b1;
    bif.cmd = 2'b11;
    tick();
    bif.cmd_valid = 1'b0;
    tick();
    n_vec++; if (bif.a !== 4'd0 || bif.b !== 4'd0 || bif.done !== 1'b1) begin n_err++; $display("FAIL clear: a=%0d b=%0d done=%b expected 0 0 1", bif.a, bif.b, bif.done); end
    tick();
    n_vec++; if (bif.done !== 1'b0 || bif.cmd_ready !== 1'b1) begin n_err++; $display("FAIL clear_end: done=%b ready=%b expected 0 1", bif.done, bif.cmd_ready); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    run_cmd(2'b00, 4'd2);
    run_cmd(2'b01, 4'd0);
    run_cmd(2'b00, 4'd1);
    bif.cmd_valid = 1'b1;
    bif.cmd = 2'b10;
    tick();
    bif.cmd_valid = 1'b0;
    tick();
`ifdef PDT_SWAP_EN
    n_vec++; if (bif.a !== 4'd2 || bif.b !== 4'd2) begin n_err++; $display("FAIL rst_mid_swp2: a=%0d b=%0d expected 2 2", bif.a, bif.b); end
`endif
    rst = 1'b1;
    #1;
    n_vec++; if (bif.cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_ready: got %b expected 0", bif.cmd_ready); end
    tick();
    n_vec++; if (bif.a !== 4'd0 || bif.b !== 4'd0) begin n_err++; $display("FAIL rst_mid_regs: a=%0d b=%0d expected 0 0", bif.a, bif.b); end
    n_vec++; if (bif.done !== 1'b0 || bif.err !== 1'b0 || bif.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_state: done=%b err=%b busy=%b expected 0 0 0", bif.done, bif.err, bif.busy); end
    rst = 1'b0;
    #1;
    n_vec++; if (bif.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_release: ready=%b expected 1", bif.cmd_ready); end
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bif.done === 1'b1 || bif.err === 1'b1) pulses++;
    end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL rst_mid_no_pulse: got %0d pulses expected 0", pulses); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bif.cmd_valid = 1'b0;
    bif.cmd = 2'b00;
    bif.data_in = 4'd0;
    test_reset();
    test_load();
    test_back_to_back();
    test_swap();
    test_data_hold();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
